// File: rtl/pattern_merge_pipe.sv
// Per-channel reduction patterns, merged and registered through a DEPTH-stage valid/ready pipe.
// Optional sticky_flags output enabled by defining PATTERN_MERGE_STICKY_EN.
module pattern_merge_pipe #(
  parameter int CH    = 3,
  parameter int W     = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                blif_clk_net,
  input  logic                blif_reset_net,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*W-1:0]     in_data,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH-1:0]       out_merge,
  output logic                out_any,
  output logic                out_all,
  output logic [CNT_W-1:0]    match_cnt,
  input  logic                cnt_clr
`ifdef PATTERN_MERGE_STICKY_EN
  ,
  output logic [CH-1:0]       sticky_flags
`endif
);

  // Majority means strictly more than half the bits set, using integer W/2.
  function automatic logic pattern_bit(input logic [W-1:0] x, input logic [1:0] mode);
    int ones;
    logic r;
    ones = 0;
    for (int i = 0; i < W; i++) begin
      ones = ones + int'(x[i]);
    end
    case (mode)
      2'b00:   r = ~|x;
      2'b01:   r = ~&x;
      2'b10:   r = ^x;
      default: r = (ones > (W / 2));
    endcase
    return r;
  endfunction

  logic [CH-1:0]    p;
  logic             adv;
  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] stg_any;
  logic [DEPTH-1:0] stg_all;
  logic [CH-1:0]    stg_merge [DEPTH];

  always_comb begin
    p = '0;
    for (int c = 0; c < CH; c++) begin
      p[c] = pattern_bit(in_data[c*W +: W], in_mode);
    end
  end

  assign out_valid = stg_valid[DEPTH-1];
  assign out_merge = stg_merge[DEPTH-1];
  assign out_any   = stg_any[DEPTH-1];
  assign out_all   = stg_all[DEPTH-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  // The whole pipe advances or holds as one; bubbles travel like beats.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      stg_valid <= '0;
      stg_any   <= '0;
      stg_all   <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        stg_merge[s] <= '0;
      end
    end else if (adv) begin
      stg_valid[0] <= in_valid;
      stg_merge[0] <= p;
      stg_any[0]   <= |p;
      stg_all[0]   <= &p;
      for (int s = 1; s < DEPTH; s++) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_merge[s] <= stg_merge[s-1];
        stg_any[s]   <= stg_any[s-1];
        stg_all[s]   <= stg_all[s-1];
      end
    end
  end

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (out_valid && out_ready && out_all && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef PATTERN_MERGE_STICKY_EN
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      sticky_flags <= '0;
    end else if (cnt_clr) begin
      sticky_flags <= '0;
    end else if (out_valid && out_ready) begin
      sticky_flags <= sticky_flags | out_merge;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Directed self-checking bench for pattern_merge_pipe (CH=3, W=5, DEPTH=2, CNT_W=4).
module tb_pattern_merge_pipe;

  logic        blif_clk_net;
  logic        blif_reset_net;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_merge;
  logic        out_any;
  logic        out_all;
  logic [3:0]  match_cnt;
  logic        cnt_clr;
`ifdef PATTERN_MERGE_STICKY_EN
  logic [2:0]  sticky_flags;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  mode;
    logic [14:0] data;
    logic [2:0]  merge;
    logic        any;
    logic        all;
    logic [3:0]  cnt;
  } vec_t;

  vec_t        tv [10];
  logic [14:0] bp_data [4];
  logic [2:0]  bp_exp [4];

  pattern_merge_pipe #(.CH(3), .W(5), .DEPTH(2), .CNT_W(4)) dut (
    .blif_clk_net   (blif_clk_net),
    .blif_reset_net (blif_reset_net),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_mode        (in_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_merge      (out_merge),
    .out_any        (out_any),
    .out_all        (out_all),
    .match_cnt      (match_cnt),
    .cnt_clr        (cnt_clr)
`ifdef PATTERN_MERGE_STICKY_EN
    ,
    .sticky_flags   (sticky_flags)
`endif
  );

  initial begin
    blif_clk_net = 1'b0;
    forever #5 blif_clk_net = ~blif_clk_net;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // One beat is presented for exactly one rising edge, then withdrawn.
  task automatic applyStimulus(input logic [1:0] mode, input logic [14:0] data);
    @(negedge blif_clk_net);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    @(negedge blif_clk_net);
    in_valid = 1'b0;
  endtask

  int tx;
  int rx;
  int stale;

  initial begin
    checks   = 0;
    failures = 0;

    // Data is packed {ch2, ch1, ch0}; merge is {p2, p1, p0}; cnt is the count after the transfer.
    tv[0] = '{2'b00, {5'b00000, 5'b00001, 5'b00000}, 3'b101, 1'b1, 1'b0, 4'd0};
    tv[1] = '{2'b11, {5'b11111, 5'b00011, 5'b10110}, 3'b101, 1'b1, 1'b0, 4'd0};
    tv[2] = '{2'b10, {5'b11111, 5'b00011, 5'b10110}, 3'b101, 1'b1, 1'b0, 4'd0};
    tv[3] = '{2'b01, {5'b00000, 5'b00000, 5'b00000}, 3'b111, 1'b1, 1'b1, 4'd1};
    tv[4] = '{2'b01, {5'b11111, 5'b11111, 5'b11111}, 3'b000, 1'b0, 1'b0, 4'd1};
    tv[5] = '{2'b00, {5'b11111, 5'b11111, 5'b11111}, 3'b000, 1'b0, 1'b0, 4'd1};
    tv[6] = '{2'b11, {5'b00111, 5'b11000, 5'b11100}, 3'b101, 1'b1, 1'b0, 4'd1};
    tv[7] = '{2'b10, {5'b01111, 5'b00011, 5'b00001}, 3'b001, 1'b1, 1'b0, 4'd1};
    tv[8] = '{2'b11, {5'b11111, 5'b11111, 5'b11111}, 3'b111, 1'b1, 1'b1, 4'd2};
    tv[9] = '{2'b00, {5'b00000, 5'b00000, 5'b00000}, 3'b111, 1'b1, 1'b1, 4'd3};

    bp_data[0] = {5'b00001, 5'b00001, 5'b00000}; bp_exp[0] = 3'b001;
    bp_data[1] = {5'b00001, 5'b00000, 5'b00001}; bp_exp[1] = 3'b010;
    bp_data[2] = {5'b00000, 5'b00001, 5'b00001}; bp_exp[2] = 3'b100;
    bp_data[3] = {5'b00001, 5'b00000, 5'b00000}; bp_exp[3] = 3'b011;

    blif_reset_net = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_merge", 32'(out_merge), 32'd0);
    checkOutput("rst_out_any", 32'(out_any), 32'd0);
    checkOutput("rst_out_all", 32'(out_all), 32'd0);
    checkOutput("rst_match_cnt", 32'(match_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge blif_clk_net);
    blif_reset_net = 1'b1;

    $display("[TB] directed pattern vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tv[i].mode, tv[i].data);
      @(negedge blif_clk_net);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_merge", i), 32'(out_merge), 32'(tv[i].merge));
      checkOutput($sformatf("vec%0d_any", i), 32'(out_any), 32'(tv[i].any));
      checkOutput($sformatf("vec%0d_all", i), 32'(out_all), 32'(tv[i].all));
      @(negedge blif_clk_net);
      checkOutput($sformatf("vec%0d_bubble", i), 32'(out_valid), 32'd0);
      checkOutput($sformatf("vec%0d_cnt", i), 32'(match_cnt), 32'(tv[i].cnt));
    end

    $display("[TB] backpressure stream");
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge blif_clk_net);
      out_ready = !(cyc >= 1 && cyc <= 6);
      if (tx < 4) begin
        in_valid = 1'b1;
        in_mode  = 2'b00;
        in_data  = bp_data[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc <= 6) begin
        checkOutput($sformatf("bp_hold_ready_c%0d", cyc), 32'(in_ready), 32'd0);
        checkOutput($sformatf("bp_hold_valid_c%0d", cyc), 32'(out_valid), 32'd1);
        checkOutput($sformatf("bp_hold_merge_c%0d", cyc), 32'(out_merge), 32'(bp_exp[0]));
      end
      if (out_valid && out_ready) begin
        if (rx < 4) checkOutput($sformatf("bp_order%0d", rx), 32'(out_merge), 32'(bp_exp[rx]));
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_sent", 32'(tx), 32'd4);
    checkOutput("bp_received", 32'(rx), 32'd4);
    checkOutput("bp_drained", 32'(out_valid), 32'd0);

    $display("[TB] counter saturation and clear");
    @(negedge blif_clk_net);
    cnt_clr = 1'b1;
    @(negedge blif_clk_net);
    cnt_clr = 1'b0;
    checkOutput("cnt_cleared", 32'(match_cnt), 32'd0);
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = '0;
    repeat (20) @(negedge blif_clk_net);
    in_valid = 1'b0;
    repeat (4) @(negedge blif_clk_net);
    checkOutput("cnt_saturated", 32'(match_cnt), 32'd15);

    applyStimulus(2'b01, 15'd0);
    @(negedge blif_clk_net);
    checkOutput("clr_coincide_valid", 32'(out_valid), 32'd1);
    checkOutput("clr_coincide_all", 32'(out_all), 32'd1);
    cnt_clr = 1'b1;
    @(negedge blif_clk_net);
    cnt_clr = 1'b0;
    checkOutput("clr_wins", 32'(match_cnt), 32'd0);
    applyStimulus(2'b01, 15'd0);
    repeat (2) @(negedge blif_clk_net);
    checkOutput("cnt_after_clr", 32'(match_cnt), 32'd1);

`ifdef PATTERN_MERGE_STICKY_EN
    $display("[TB] sticky flags");
    @(negedge blif_clk_net);
    cnt_clr = 1'b1;
    @(negedge blif_clk_net);
    cnt_clr = 1'b0;
    checkOutput("sticky_clear0", 32'(sticky_flags), 32'd0);
    applyStimulus(2'b00, {5'b00001, 5'b00001, 5'b00000});
    repeat (2) @(negedge blif_clk_net);
    checkOutput("sticky_001", 32'(sticky_flags), 32'b001);
    applyStimulus(2'b00, {5'b00000, 5'b00001, 5'b00001});
    repeat (2) @(negedge blif_clk_net);
    checkOutput("sticky_101", 32'(sticky_flags), 32'b101);
    cnt_clr = 1'b1;
    @(negedge blif_clk_net);
    cnt_clr = 1'b0;
    checkOutput("sticky_cleared", 32'(sticky_flags), 32'd0);
`endif

    $display("[TB] reset with beats in flight");
    @(negedge blif_clk_net);
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_data  = '0;
    @(negedge blif_clk_net);
    @(negedge blif_clk_net);
    in_valid = 1'b0;
    checkOutput("inflight_valid", 32'(out_valid), 32'd1);
    blif_reset_net = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_merge", 32'(out_merge), 32'd0);
    checkOutput("async_rst_cnt", 32'(match_cnt), 32'd0);
    @(negedge blif_clk_net);
    blif_reset_net = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge blif_clk_net);
      if (out_valid) stale++;
    end
    checkOutput("no_stale_beat", 32'(stale), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
